// File: rtl/alu_pkg.sv
// Shared opcode map, FSM encoding and opcode legality check for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_EQ  = 4'd1;
    localparam logic [3:0] OP_GT  = 4'd2;
    localparam logic [3:0] OP_LT  = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_MOV = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    function automatic logic is_legal(input logic [3:0] op);
        return (op <= OP_MUL);
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier: one partial product per cycle, WIDTH cycles after start.
// done_o is high in the last iteration cycle; prod_o is the value the accumulator takes on that edge.
module alu_mul_iter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] prod_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum;

    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        a_d    = a_q;
        b_d    = b_q;
        sum    = acc_q + (b_q[0] ? a_q : '0);
        done_o = (cnt_q == CW'(1));
        prod_o = sum;
        if (start_i) begin
            cnt_d = CW'(WIDTH);
            acc_d = '0;
            a_d   = a_i;
            b_d   = b_i;
        end else if (cnt_q != '0) begin
            // Bits shifted out of a_q only affect product bits above WIDTH.
            acc_d = sum;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            acc_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            a_q   <= a_d;
            b_q   <= b_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake on both sides; MUL iterates in alu_mul_iter,
// every other op completes in the accept cycle.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CODE  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [CODE-1:0]  opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             z,
    output logic             carry,
    output logic             err
);

    state_e           state_q, state_d;
    logic             ov_q, ov_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             z_q, z_d;
    logic             c_q, c_d;
    logic             e_q, e_d;

    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_prod;

    logic [WIDTH:0]   add_s;
    logic [WIDTH-1:0] r_y;
    logic             r_z, r_c, r_e;

    assign in_ready  = (state_q == ST_IDLE) && (!ov_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (opcode == OP_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start_i(mul_start),
        .a_i    (a),
        .b_i    (b),
        .done_o (mul_done),
        .prod_o (mul_prod)
    );

    // Single-cycle result mux; MUL is produced by the iterator instead.
    always_comb begin
        add_s = {1'b0, a} + {1'b0, b};
        r_y   = '0;
        r_c   = 1'b0;
        r_e   = !is_legal(opcode);
        case (opcode)
            OP_ADD: begin r_y = add_s[WIDTH-1:0]; r_c = add_s[WIDTH]; end
            OP_SUB: begin r_y = a - b;            r_c = (a < b);      end
            OP_AND: r_y = a & b;
            OP_OR:  r_y = a | b;
            OP_XOR: r_y = a ^ b;
            OP_MOV: r_y = b;
            default: r_y = '0;
        endcase
        case (opcode)
            OP_EQ:   r_z = (a == b);
            OP_GT:   r_z = (a > b);
            OP_LT:   r_z = (a < b);
            default: r_z = r_e ? 1'b0 : (r_y == '0);
        endcase
    end

    always_comb begin
        state_d = state_q;
        ov_d    = ov_q;
        y_d     = y_q;
        z_d     = z_q;
        c_d     = c_q;
        e_d     = e_q;
        if (ov_q && out_ready) ov_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mul_start) begin
                    state_d = ST_MUL;
                end else if (accept) begin
                    ov_d = 1'b1;
                    y_d  = r_y;
                    z_d  = r_z;
                    c_d  = r_c;
                    e_d  = r_e;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_d = ST_IDLE;
                    ov_d    = 1'b1;
                    y_d     = mul_prod;
                    z_d     = (mul_prod == '0);
                    c_d     = 1'b0;
                    e_d     = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ov_q    <= 1'b0;
            y_q     <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            e_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ov_q    <= ov_d;
            y_q     <= y_d;
            z_q     <= z_d;
            c_q     <= c_d;
            e_q     <= e_d;
        end
    end

    assign out_valid = ov_q;
    assign y         = y_q;
    assign z         = z_q;
    assign carry     = c_q;
    assign err       = e_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, handshaked successor to the team's 4-bit combinational ALU: parametrised operand width, 4-bit opcode space, status flags, and an iterative multi-cycle multiply.
- Sits between the decode/operand-fetch stage and writeback.
- Uses valid/ready on input and output so that a stalled writeback holds the ALU.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2 to 32.
- CODE, 4, opcode width; fixed at 4, exposed only for port sizing.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and opcode are valid.
- in_ready  out  1  ALU accepts an operation this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- opcode  in  CODE  operation select.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer takes the result this cycle.
- y  out  WIDTH  result.
- z  out  1  compare result, or zero flag.
- carry  out  1  carry (ADD) or borrow (SUB).
- err  out  1  illegal opcode was executed.

Behaviour:
- Opcodes: 0 ADD, 1 EQ, 2 GT, 3 LT, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 MOV (y=b), 9 MUL. Codes 10–15 are illegal.
- Arithmetic is unsigned and modulo 2^WIDTH.
- ADD: carry = bit WIDTH of a+b.
- SUB: carry = 1 when a<b.
- MUL: y = low WIDTH bits of a*b.
- EQ/GT/LT: y=0, z = compare result.
- All other legal ops: z = (y==0). carry=0 except for ADD and SUB.
- Illegal opcodes: y=0, z=0, carry=0, err=1. err=0 for every legal op.
- Transfer rules: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- FSM states:
  - IDLE: no multiply in progress.
  - MUL: shift-add iteration.
- in_ready = (state==IDLE) && (!out_valid || out_ready), so an accept and a drain can occur in the same cycle.
- Single-cycle ops:
  - Accepted at edge k; result and flags are registered at edge k; out_valid=1 after edge k.
  - Back-to-back throughput is one op per cycle while out_ready=1.
- MUL:
  - Accept at edge k: capture a, b; clear the accumulator; set the iteration counter to WIDTH; go to MUL. in_ready=0 while in MUL.
  - Each MUL cycle: if b_shift[0], add a_shift to the accumulator; shift a left and b right; decrement the counter.
  - On the edge where the counter reaches 0: load y and flags, set out_valid, return to IDLE.
  - out_valid rises after edge k+WIDTH, i.e. latency WIDTH+1 cycles from the accept cycle.
  - The multiply does not start unless the output register is free or draining; this is guaranteed by in_ready.
- Output hold: while out_valid && !out_ready, y, z, carry and err are stable and in_ready=0.
- out_valid falls on an output transfer unless a new result is loaded on the same edge.
- Reset (asynchronous, any cycle including mid-MUL): state=IDLE; out_valid=0; y=0; z=0; carry=0; err=0; accumulator and counter cleared. The in-flight multiply is discarded and no result is produced.
- Inputs are ignored while in_ready=0; an ignored opcode does not affect err.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams OP_ADD through OP_MUL;
  - state encoding ST_IDLE, ST_MUL;
  - function is_legal(opcode).
- One sub-module, alu_mul_iter: the shift-add multiplier datapath with start/done, parametrised by WIDTH.
- The combinational single-cycle op mux and the handshake FSM stay in alu_seq.

Test Plan (all with WIDTH=4):
- ADD a=9, b=8, out_ready=1 -> next cycle out_valid=1, y=1, carry=1, z=0, err=0.
- Back-to-back SUB 3-5, EQ 7==7, LT 2<9, one per cycle -> y=14/carry=1; z=1; z=1, each on consecutive cycles with in_ready held at 1.
- MUL a=5, b=3 -> in_ready=0 for 4 cycles, out_valid after 5 cycles, y=15, z=0. Then MUL 8*4 -> y=0, z=1.
- Backpressure:
  - Stimulus: XOR a=12, b=10 with out_ready=0 for 3 cycles.
  - Response: y=6 held stable; in_ready=0; a second op presented is not accepted.
  - Releasing out_ready -> same-cycle accept of the next op.
- Illegal opcode 15 -> y=0, z=0, carry=0, err=1. The following MOV b=7 -> y=7, err=0.
- Assert rst_n=0 two cycles into MUL 6*6 -> out_valid=0 and y=0 immediately. After release, in_ready=1 and no stale result appears.
